uart_rx_cfg: RTL
================

# uart_rx_cfg

Runtime-configurable UART receiver with start-edge realignment, 3-sample majority voting, parity/framing/break detection and an output FIFO with valid/ready handshake. It replaces the fixed 8N1 receiver in the UART-AXI4 bridge front end. The bridge parser drains it through the FIFO, so byte loss is limited to a flagged overrun.

## Interface
- OVERSAMPLE, 16: samples per bit; even, ≥8.
- DIV_WIDTH, 16: width of the runtime baud divisor.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.
- SYNC_STAGES, 3: input synchronizer depth, ≥2.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset; asynchronous, active-high.
- uart_rx  in  1  serial line, idle high.
- cfg_baud_div  in  DIV_WIDTH  clk cycles per oversample tick; 0 treated as 1.
- cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none.
- cfg_stop2  in  1  1 = two stop bits checked.
- m_data  out  8  FIFO head byte, right-justified, unused MSBs 0.
- m_frame_err  out  1  FIFO head: a stop bit sampled 0.
- m_parity_err  out  1  FIFO head: parity mismatch.
- m_break  out  1  FIFO head: break condition.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts head.
- overrun  out  1  1-cycle pulse: frame dropped, FIFO full.
- rx_busy  out  1  state != IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries.

## Operation
- Synchronizer resets to all-ones; rx_s is its last stage.
- Config latched into shadow registers on IDLE→START; mid-frame cfg changes have no effect on the current frame.
- Tick generator: counter 0..div-1; tick on div-1. Tick counter and sample index (0..OVERSAMPLE-1) both clear on IDLE→START, so start-edge alignment is exact.
- Bit value = majority of rx_s at sample indices OS/2-1, OS/2 and OS/2+1. The decision is taken on the OS/2+1 tick ("decision tick"). The bit period ends on the OS-1 tick, and the index then wraps to 0.
- States:
  - IDLE: rx_s=0 → START.
  - START: at the decision tick, majority 1 → IDLE (false start, no push); otherwise continue at end of period → DATA.
  - DATA: shift in LSB-first at each decision tick. After N bits, at end of period → PARITY if enabled, else STOP1.
  - PARITY: at the decision tick compare against the data. Even: total ones including parity is even. Odd: total is odd.
  - STOP1: at the decision tick record the bit. If cfg_stop2, at end of period → STOP2; else evaluate and push.
  - STOP2: at the decision tick record the bit, evaluate and push.
  - Evaluate: frame_err = any stop bit 0. Break = data all 0 AND parity bit 0 (if enabled) AND stop1 0. On break, data=0 and frame_err=1. After push → IDLE, or → BRK_WAIT if break.
  - BRK_WAIT: stay until rx_s=1, then → IDLE. A continuous low line yields exactly one entry.
- FIFO entry = {break, parity_err, frame_err, data}.
  - Pop when m_valid && m_ready.
  - Push to a full FIFO with no simultaneous pop: entry dropped, overrun pulses.
  - Push to a full FIFO with a simultaneous pop: accepted, no overrun, count unchanged.
  - Order strictly FIFO.

## Timing
- Reset (asynchronous): state IDLE, FIFO empty. m_valid, m_data, all m_* flags, overrun, rx_busy and fifo_count = 0.
- Reset asserted mid-frame aborts the frame immediately. Nothing is pushed.
- Start detect: falling edge at uart_rx gives IDLE→START SYNC_STAGES+1 cycles later. rx_busy rises the same cycle.
- Push is written at the edge ending the final decision-tick cycle. m_valid and fifo_count update on the next cycle. overrun pulses in that same cycle.
- Head outputs hold stable while m_valid && !m_ready.
- After a pop, the new head (or m_valid=0) is visible the next cycle.
- Bit period = OVERSAMPLE × max(cfg_baud_div,1) cycles.
- rx_busy falls half a stop bit after its start (at the push), which allows back-to-back frames.

## Test plan
- 8N1, cfg_baud_div=4, send 0xA5 with m_ready=1 → one entry: m_data=0xA5, all flags 0, m_valid high for exactly 1 cycle.
- 7E1, send 7-bit 0x55 with parity bit 1 (correct parity is 0) → m_data=0x55, m_parity_err=1, m_frame_err=0.
- 8N2, send 0x3C with the second stop bit 0 → m_data=0x3C, m_frame_err=1. Repeat with a valid second stop → m_frame_err=0.
- 8N1, hold line low 12 bit times, then high → exactly one entry: m_data=0x00, m_break=1, m_frame_err=1. rx_busy stays 1 until the line returns high.
- FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 → fifo_count=4, one overrun pulse on the 5th byte. Drain returns 0x01..0x04 in order. A push with a simultaneous pop while full gives no overrun.
- Low glitch of 3 clk at cfg_baud_div=4 → START then IDLE, no entry, overrun=0. Assert rst mid-byte → all outputs 0 that cycle, fifo_count=0.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - receive-FIFO head handshake bundle for uart_rx_cfg
// Purpose: groups the FIFO head byte, its status flags and the valid/ready pair.
// Ports (master = receiver, slave = consumer):
//   m_data        8  head byte, right-justified, unused MSBs 0
//   m_frame_err   1  head: a stop bit sampled 0
//   m_parity_err  1  head: parity mismatch
//   m_break       1  head: break condition
//   m_valid       1  FIFO not empty
//   m_ready       1  consumer accepts head (driven by slave)
`timescale 1ns/1ps
interface uart_rx_cfg_if;
    logic [7:0] m_data;
    logic       m_frame_err;
    logic       m_parity_err;
    logic       m_break;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data, m_frame_err, m_parity_err, m_break, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_frame_err, m_parity_err, m_break, m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with majority voting and output FIFO
// Purpose: oversampled UART receiver, 5..8 data bits, none/even/odd parity, 1 or 2
//          stop bits, break detection, results queued in a small FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   uart_rx         serial line, idle high
//   cfg_baud_div    clk cycles per oversample tick (0 behaves as 1)
//   cfg_data_bits   00=5 .. 11=8 data bits
//   cfg_parity      01=even, 10=odd, otherwise none
//   cfg_stop2       1 = two stop bits checked
//   m_if            FIFO head handshake (master side)
//   overrun         1-cycle pulse when a frame is dropped on a full FIFO
//   rx_busy         receiver not idle
//   fifo_count      occupied FIFO entries
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rx,
    input  logic [DIV_WIDTH-1:0]              cfg_baud_div,
    input  logic [1:0]                        cfg_data_bits,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    uart_rx_cfg_if.master                     m_if,
    output logic                              overrun,
    output logic                              rx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [SW-1:0] SIDX_A   = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] SIDX_B   = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] SIDX_DEC = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] SIDX_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [DIV_WIDTH-1:0]    r_div_cnt;
    logic [SW-1:0]           r_sidx;
    logic [3:0]              r_nbits;
    logic [3:0]              r_bitcnt;
    logic [1:0]              r_par;
    logic                    r_stop2;
    logic                    r_s0, r_s1;
    logic [7:0]              r_shift;
    logic                    r_par_bit;
    logic                    r_stop1;
    logic [10:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr, r_rd;
    logic [CW-1:0]           r_count;
    logic                    r_overrun;

    logic                    w_rx_s;
    logic [DIV_WIDTH-1:0]    w_div_m1;
    logic                    w_tick, w_dec, w_end, w_bit;
    logic                    w_par_en;
    logic [7:0]              w_data;
    logic                    w_stop1_v, w_stop2_v, w_ones;
    logic                    w_brk, w_ferr, w_perr;
    logic [10:0]             w_entry;
    logic                    w_push, w_full, w_valid, w_pop, w_push_ok;

    assign w_rx_s   = r_sync[SYNC_STAGES-1];
    assign w_div_m1 = (r_div == '0) ? '0 : r_div - DIV_WIDTH'(1);
    assign w_tick   = (r_div_cnt == w_div_m1);
    assign w_dec    = w_tick && (r_sidx == SIDX_DEC);
    assign w_end    = w_tick && (r_sidx == SIDX_END);
    // Two stored samples plus the live sample on the decision tick.
    assign w_bit    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_par_en = (r_par == 2'b01) || (r_par == 2'b10);

    // Bits were shifted in from the MSB end, so fewer than 8 need right-justifying.
    assign w_data    = r_shift >> (4'd8 - r_nbits);
    assign w_stop1_v = (r_state == S_STOP1) ? w_bit : r_stop1;
    assign w_stop2_v = (r_state == S_STOP2) ? w_bit : 1'b1;
    assign w_ones    = (^w_data) ^ r_par_bit;
    assign w_brk     = (w_data == 8'h00) && (!w_par_en || !r_par_bit) && !w_stop1_v;
    assign w_ferr    = !w_stop1_v || !w_stop2_v || w_brk;
    assign w_perr    = w_par_en && ((r_par == 2'b01) ? w_ones : !w_ones);
    assign w_entry   = {w_brk, w_perr, w_ferr, (w_brk ? 8'h00 : w_data)};
    assign w_push    = w_dec && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && m_if.m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync    <= '1;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_sidx    <= '0;
            r_nbits   <= 4'd8;
            r_bitcnt  <= '0;
            r_par     <= '0;
            r_stop2   <= 1'b0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_stop1   <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
            if (r_state == S_IDLE) begin
                // Holding the counters at zero makes the start edge the period origin.
                r_div_cnt <= '0;
                r_sidx    <= '0;
                if (!w_rx_s) begin
                    r_state  <= S_START;
                    r_div    <= cfg_baud_div;
                    r_nbits  <= 4'd5 + {2'b00, cfg_data_bits};
                    r_par    <= cfg_parity;
                    r_stop2  <= cfg_stop2;
                    r_bitcnt <= '0;
                end
            end else begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sidx    <= (r_sidx == SIDX_END) ? '0 : r_sidx + SW'(1);
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
                end
                if (w_tick && (r_sidx == SIDX_A)) r_s0 <= w_rx_s;
                if (w_tick && (r_sidx == SIDX_B)) r_s1 <= w_rx_s;

                case (r_state)
                    S_START: begin
                        if (w_dec && w_bit)
                            r_state <= S_IDLE;
                        else if (w_end)
                            r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (w_dec) begin
                            r_shift  <= {w_bit, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                        if (w_end && (r_bitcnt == r_nbits))
                            r_state <= w_par_en ? S_PARITY : S_STOP1;
                    end
                    S_PARITY: begin
                        if (w_dec) r_par_bit <= w_bit;
                        if (w_end) r_state <= S_STOP1;
                    end
                    S_STOP1: begin
                        if (w_dec) begin
                            r_stop1 <= w_bit;
                            if (!r_stop2) r_state <= w_brk ? S_BRK_WAIT : S_IDLE;
                        end else if (w_end && r_stop2) begin
                            r_state <= S_STOP2;
                        end
                    end
                    S_STOP2: begin
                        if (w_dec) r_state <= w_brk ? S_BRK_WAIT : S_IDLE;
                    end
                    S_BRK_WAIT: begin
                        if (w_rx_s) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop)     r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is gated so an empty FIFO presents all zeros regardless of stale storage.
    assign m_if.m_valid      = w_valid;
    assign m_if.m_data       = w_valid ? r_mem[r_rd][7:0] : 8'h00;
    assign m_if.m_frame_err  = w_valid && r_mem[r_rd][8];
    assign m_if.m_parity_err = w_valid && r_mem[r_rd][9];
    assign m_if.m_break      = w_valid && r_mem[r_rd][10];
    assign overrun           = r_overrun;
    assign rx_busy           = (r_state != S_IDLE);
    assign fifo_count        = r_count;
endmodule
